// File: rtl/uart16550_wb_ctrl.sv
// Wishbone master that configures one 16550 UART and bridges it to
// valid/ready byte streams.
//
// Ports:
//   wb_clk_i / wb_rst_i : clock, async active-high reset
//   wb_*                : Wishbone master (adr, dat, we, cyc, stb, ack)
//   tx_*                : transmit byte stream in (valid/ready)
//   rx_*                : receive byte stream out (valid/ready)
//   reconfig_i          : pulse to rerun the configuration sequence
//   cfg_done_o          : configuration complete
//   rx_overrun_o        : sticky, LSR overrun bit was seen
//   bus_err_o           : sticky, an ack timeout occurred
module uart16550_wb_ctrl #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic       reconfig_i,
  output logic       cfg_done_o,
  output logic       rx_overrun_o,
  output logic       bus_err_o
);

  typedef enum logic [3:0] {
    CFG0, CFG1, CFG2, CFG3, CFG4, CFG5,
    POLL, GAP, RD_RBR, TX_WAIT, WR_THR
  } state_t;

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  state_t        state_q;
  logic          busy_q;
  logic [TW-1:0] tmo_q;
  logic [GW-1:0] gap_q;
  logic [4:0]    burst_q;
  logic [7:0]    tx_byte_q;
  logic          rc_pend_q;
  logic [2:0]    wb_adr_q;
  logic [7:0]    wb_dat_q;
  logic          wb_we_q;
  logic          wb_cyc_q;
  logic          wb_stb_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          cfg_done_q;
  logic          ovr_q;
  logic          err_q;

  logic [2:0] req_adr_d;
  logic [7:0] req_dat_d;
  logic       req_we_d;
  logic [7:0] rd_data;
  logic       xfer_done;
  logic       rc_go;
  logic       tx_hs;
  logic       start;

  always_comb begin
    req_adr_d = 3'd0;
    req_dat_d = 8'h00;
    req_we_d  = 1'b0;
    unique case (state_q)
      CFG0: begin
        req_adr_d = 3'd3;
        req_dat_d = LCR_VAL | 8'h80;
        req_we_d  = 1'b1;
      end
      CFG1: begin
        req_adr_d = 3'd0;
        req_dat_d = DIVISOR[7:0];
        req_we_d  = 1'b1;
      end
      CFG2: begin
        req_adr_d = 3'd1;
        req_dat_d = DIVISOR[15:8];
        req_we_d  = 1'b1;
      end
      CFG3: begin
        req_adr_d = 3'd3;
        req_dat_d = LCR_VAL & 8'h7F;
        req_we_d  = 1'b1;
      end
      CFG4: begin
        req_adr_d = 3'd2;
        req_dat_d = FCR_VAL;
        req_we_d  = 1'b1;
      end
      CFG5: begin
        req_adr_d = 3'd1;
        req_we_d  = 1'b1;
      end
      POLL:   req_adr_d = 3'd5;
      WR_THR: begin
        req_dat_d = tx_byte_q;
        req_we_d  = 1'b1;
      end
      default: req_adr_d = 3'd0;
    endcase
  end

  // A timed-out read is treated as returning zero.
  assign rd_data   = wb_ack_i ? wb_dat_i : 8'h00;
  assign xfer_done = busy_q && (wb_ack_i || tmo_q == TMO_LAST);
  assign rc_go     = reconfig_i && cfg_done_q;
  assign tx_ready_o = cfg_done_q && state_q == TX_WAIT
                      && !burst_q[4];
  assign tx_hs     = tx_valid_i && tx_ready_o;
  assign start     = !busy_q && state_q != GAP
                     && state_q != TX_WAIT
                     && !(state_q == POLL && rc_go);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= CFG0;
      busy_q     <= 1'b0;
      tmo_q      <= '0;
      gap_q      <= '0;
      burst_q    <= 5'd0;
      tx_byte_q  <= 8'h00;
      rc_pend_q  <= 1'b0;
      wb_adr_q   <= 3'd0;
      wb_dat_q   <= 8'h00;
      wb_we_q    <= 1'b0;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      if (busy_q) begin
        if (xfer_done) begin
          wb_cyc_q <= 1'b0;
          wb_stb_q <= 1'b0;
          wb_we_q  <= 1'b0;
          busy_q   <= 1'b0;
          if (!wb_ack_i) err_q <= 1'b1;
          unique case (state_q)
            CFG0: state_q <= CFG1;
            CFG1: state_q <= CFG2;
            CFG2: state_q <= CFG3;
            CFG3: state_q <= CFG4;
            CFG4: state_q <= CFG5;
            CFG5: begin
              cfg_done_q <= 1'b1;
              state_q    <= POLL;
            end
            POLL: begin
              if (rd_data[1]) ovr_q <= 1'b1;
              if (rc_pend_q || rc_go) begin
                cfg_done_q <= 1'b0;
                rc_pend_q  <= 1'b0;
                state_q    <= CFG0;
              end else if (rd_data[0] && !rx_valid_q) begin
                state_q <= RD_RBR;
              end else if (rd_data[5] && tx_valid_i) begin
                burst_q <= 5'd0;
                state_q <= TX_WAIT;
              end else begin
                gap_q   <= '0;
                state_q <= GAP;
              end
            end
            RD_RBR: begin
              rx_data_q  <= rd_data;
              rx_valid_q <= 1'b1;
              state_q    <= POLL;
            end
            WR_THR:  state_q <= TX_WAIT;
            default: state_q <= state_q;
          endcase
        end else begin
          tmo_q <= tmo_q + TW'(1);
          // Hold a reconfig request seen during an LSR poll.
          if (rc_go && state_q == POLL) rc_pend_q <= 1'b1;
        end
      end else if (start) begin
        wb_cyc_q <= 1'b1;
        wb_stb_q <= 1'b1;
        wb_adr_q <= req_adr_d;
        wb_dat_q <= req_dat_d;
        wb_we_q  <= req_we_d;
        busy_q   <= 1'b1;
        tmo_q    <= '0;
      end else begin
        unique case (state_q)
          GAP: begin
            if (rc_go) begin
              cfg_done_q <= 1'b0;
              rc_pend_q  <= 1'b0;
              state_q    <= CFG0;
            end else if (gap_q == GAP_LAST) begin
              state_q <= POLL;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          TX_WAIT: begin
            if (tx_hs) begin
              tx_byte_q <= tx_data_i;
              burst_q   <= burst_q + 5'd1;
              state_q   <= WR_THR;
            end else if (rc_go) begin
              cfg_done_q <= 1'b0;
              rc_pend_q  <= 1'b0;
              state_q    <= CFG0;
            end else begin
              state_q <= POLL;
            end
          end
          POLL: begin
            cfg_done_q <= 1'b0;
            rc_pend_q  <= 1'b0;
            state_q    <= CFG0;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign wb_adr_o     = wb_adr_q;
  assign wb_dat_o     = wb_dat_q;
  assign wb_we_o      = wb_we_q;
  assign wb_cyc_o     = wb_cyc_q;
  assign wb_stb_o     = wb_stb_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign cfg_done_o   = cfg_done_q;
  assign rx_overrun_o = ovr_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_uart16550_wb_ctrl.sv
// Self-checking bench for uart16550_wb_ctrl: a behavioural 16550 slave
// model with scoreboard queues for config writes, THR bytes and RX bytes.
module tb_uart16550_wb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_we_o, wb_cyc_o, wb_stb_o;
  logic       wb_ack_i = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready = 1'b0;
  logic       reconfig = 1'b0;
  logic       cfg_done_o, rx_overrun_o, bus_err_o;

  uart16550_wb_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
    .reconfig_i(reconfig), .cfg_done_o(cfg_done_o),
    .rx_overrun_o(rx_overrun_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues and model state
  logic [11:0] cfg_exp[$];
  logic [7:0]  thr_exp[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  tx_src[$];
  logic [7:0]  rx_fifo[$];
  logic [7:0]  tx_fifo[$];
  int          bursts_seen[$];
  int          burst_ref[$];
  logic [7:0]  lcr = 8'h00;
  logic [7:0]  last_lsr = 8'h00;
  bit          oe_pend = 0, loop_en = 0, noack_arm = 0;
  bit          in_txn = 0, hang = 0, cfg_prev = 0;
  int          lat = 0, hang_cnt = 0, hang_done = 0;
  int          lsr_reads = 0, rbr_reads = 0, burst = 0, drain_tmr = 0;

  task automatic push_cfg();
    cfg_exp.push_back({1'b1, 3'd3, 8'h83});
    cfg_exp.push_back({1'b1, 3'd0, 8'h1B});
    cfg_exp.push_back({1'b1, 3'd1, 8'h00});
    cfg_exp.push_back({1'b1, 3'd3, 8'h03});
    cfg_exp.push_back({1'b1, 3'd2, 8'h07});
    cfg_exp.push_back({1'b1, 3'd1, 8'h00});
  endtask

  // One completed access: scoreboard checks plus register side effects.
  task automatic xfer();
    logic [7:0]  r;
    logic [11:0] e;
    logic        te;
    r = 8'h00;
    if (!cfg_done_o) begin
      chk("cfg_pending", cfg_exp.size() > 0, 1);
      if (cfg_exp.size() > 0) begin
        e = cfg_exp.pop_front();
        chk("cfg_access", {wb_we_o, wb_adr_o, wb_dat_o}, e);
      end
    end
    if (wb_we_o) begin
      if (wb_adr_o == 3'd3) lcr = wb_dat_o;
      if (cfg_done_o) begin
        chk("wr_adr", wb_adr_o, 0);
        chk("thr_pending", thr_exp.size() > 0, 1);
        if (thr_exp.size() > 0) chk("thr_data", wb_dat_o, thr_exp.pop_front());
        chk("thr_room", tx_fifo.size() < 16, 1);
        burst++;
      end
      if (wb_adr_o == 3'd0 && !lcr[7]) tx_fifo.push_back(wb_dat_o);
    end else if (wb_adr_o == 3'd5) begin
      te = (tx_fifo.size() == 0);
      r = {1'b0, te, te, 3'b000, oe_pend, rx_fifo.size() > 0};
      oe_pend = 0;
      last_lsr = r;
      lsr_reads++;
      if (burst > 0) begin
        bursts_seen.push_back(burst);
        burst = 0;
      end
    end else if (wb_adr_o == 3'd0) begin
      chk("rbr_after_dr", last_lsr[0], 1);
      chk("rbr_hold_empty", rx_valid_o, 0);
      if (rx_fifo.size() > 0) r = rx_fifo.pop_front();
      rbr_reads++;
    end
    wb_dat_i = r;
  endtask

  // Slave model and monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      wb_ack_i = 1'b0;
      in_txn = 0;
      hang = 0;
      cfg_prev = 0;
    end else begin
      if (tx_ready_o) chk("txrdy_idle_bus", wb_cyc_o, 0);
      if (rx_valid_o && rx_ready) begin
        chk("rx_pending", rx_exp.size() > 0, 1);
        if (rx_exp.size() > 0) chk("rx_data", rx_data_o, rx_exp.pop_front());
      end
      if (cfg_done_o && !cfg_prev) chk("cfg_six_writes", cfg_exp.size(), 0);
      cfg_prev = cfg_done_o;
      drain_tmr++;
      if (drain_tmr >= 8) begin
        drain_tmr = 0;
        if (tx_fifo.size() > 0) begin
          if (loop_en) rx_fifo.push_back(tx_fifo[0]);
          void'(tx_fifo.pop_front());
        end
      end
      if (wb_ack_i) begin
        wb_ack_i = 1'b0;
      end else begin
        if (!in_txn && wb_cyc_o && wb_stb_o) begin
          in_txn = 1;
          lat = $urandom_range(0, 2);
          hang = noack_arm && !wb_we_o && wb_adr_o == 3'd5;
          if (hang) noack_arm = 0;
          hang_cnt = 0;
        end
        if (in_txn) begin
          if (!wb_cyc_o) begin
            in_txn = 0;
            chk("drop_only_on_timeout", hang, 1);
            if (hang) begin
              chk("tmo_len", hang_cnt, 255);
              chk("tmo_bus_err", bus_err_o, 1);
              hang_done++;
              hang = 0;
            end
          end else if (hang) begin
            hang_cnt++;
          end else if (lat == 0) begin
            xfer();
            wb_ack_i = 1'b1;
            in_txn = 0;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // TX stream driver
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = tx_valid && tx_ready_o;
      @(posedge clk);
      #1;
      if (hs && tx_src.size() > 0) void'(tx_src.pop_front());
      tx_valid = tx_src.size() > 0;
      tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
    end
  end

  task automatic wait_cfg(input string nm);
    int n;
    n = 0;
    while (!cfg_done_o && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, cfg_done_o, 1);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((rx_exp.size() > 0 || thr_exp.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, rx_exp.size() + thr_exp.size(), 0);
  endtask

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [7:0] lb[3];
    logic [7:0] b;
    int n0, n, rem;
    lb[0] = 8'h55; lb[1] = 8'hAA; lb[2] = 8'h0F;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
    chk("rst_flags", {tx_ready_o, rx_valid_o, cfg_done_o,
                      rx_overrun_o, bus_err_o}, 0);
    chk("rst_rxd", rx_data_o, 0);
    push_cfg();
    @(posedge clk); #1 rst = 0;
    wait_cfg("cfg_done_init");

    // Loopback of three bytes
    rx_ready = 1; loop_en = 1;
    for (int i = 0; i < 3; i++) begin
      tx_src.push_back(lb[i]);
      thr_exp.push_back(lb[i]);
      rx_exp.push_back(lb[i]);
    end
    wait_drain("drain_loop", 4000);
    loop_en = 0;

    // 20-byte burst: split into chunks of at most 16 per LSR poll
    bursts_seen.delete();
    burst = 0;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      tx_src.push_back(b);
      thr_exp.push_back(b);
    end
    rem = 20;
    burst_ref.delete();
    while (rem > 0) begin
      burst_ref.push_back(rem > 16 ? 16 : rem);
      rem -= (rem > 16 ? 16 : rem);
    end
    wait_drain("drain_burst", 5000);
    repeat (60) @(posedge clk);
    chk("burst_count", bursts_seen.size(), burst_ref.size());
    for (int i = 0; i < burst_ref.size(); i++)
      if (i < bursts_seen.size()) chk("burst_len", bursts_seen[i], burst_ref[i]);

    // RX backpressure
    #1 rx_ready = 0;
    n0 = rbr_reads;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      rx_fifo.push_back(b);
      rx_exp.push_back(b);
    end
    repeat (400) @(posedge clk);
    #1;
    chk("bp_rbr_reads", rbr_reads - n0, 1);
    chk("bp_valid", rx_valid_o, 1);
    chk("bp_data", rx_data_o, rx_exp[0]);
    rx_ready = 1;
    wait_drain("drain_bp", 3000);

    // Random mixed traffic
    for (int it = 0; it < 25; it++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          tx_src.push_back(b);
          thr_exp.push_back(b);
        end
      end else begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          rx_fifo.push_back(b);
          rx_exp.push_back(b);
        end
      end
      rx_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    #1 rx_ready = 1;
    wait_drain("drain_rand", 8000);

    // Overrun flag from LSR[1]
    oe_pend = 1;
    n = 0;
    while (!rx_overrun_o && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 chk("overrun_sticky", rx_overrun_o, 1);

    // Missing ack on an LSR read
    n0 = hang_done;
    noack_arm = 1;
    n = 0;
    while (hang_done == n0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("tmo_seen", hang_done - n0, 1);
    n0 = lsr_reads;
    n = 0;
    while (lsr_reads == n0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("poll_after_tmo", lsr_reads > n0, 1);
    chk("bus_err_sticky", bus_err_o, 1);

    // Reconfig pulse while in GAP
    n0 = lsr_reads;
    n = 0;
    while (lsr_reads == n0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    push_cfg();
    @(posedge clk); #1 reconfig = 1;
    @(posedge clk); #1 reconfig = 0;
    chk("rc_cfg_drop", cfg_done_o, 0);
    wait_cfg("cfg_done_rc");

    // Async reset in the middle of a config write
    @(posedge clk); #1 rst = 1;
    cfg_exp.delete();
    push_cfg();
    @(posedge clk); #1 rst = 0;
    chk("rst_sticky_clr", {rx_overrun_o, bus_err_o}, 0);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cyc_seen", wb_cyc_o, 1);
    #2 rst = 1;
    #1 chk("async_cyc_drop", {wb_cyc_o, wb_stb_o}, 0);
    cfg_exp.delete();
    push_cfg();
    @(posedge clk); #1 rst = 0;
    wait_cfg("cfg_done_rst");

    repeat (20) @(posedge clk);
    #1;
    chk("final_queues", rx_exp.size() + thr_exp.size() + cfg_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart16550_wb_ctrl.md
Name: uart16550_wb_ctrl

Overview:
- Wishbone master that configures and services one 16550-compatible UART (uart_top) on behalf of simple byte-stream clients.
- After reset it programs the divisor, line control, FIFO control and interrupt enable registers, then polls LSR.
- It moves bytes between a valid/ready TX stream and THR, and between RBR and a valid/ready RX stream.
- It sits between SoC logic or a testbench and the UART's Wishbone slave port, replacing a generic bus-functional master.

Parameters:
- DIVISOR, 16'd27, baud divisor written to DLM:DLL.
- LCR_VAL, 8'h03, line control value (8N1); bit 7 is forced to 0 in the final LCR write.
- FCR_VAL, 8'h07, FIFO control value (enable, clear both FIFOs, RX trigger 1).
- ACK_TIMEOUT, 255, cycles to wait for wb_ack_i before flagging a bus error.
- POLL_GAP, 4, idle cycles between consecutive LSR polls when there is no work.

Ports:
- wb_clk_i, input, 1, system clock; all logic on the rising edge.
- wb_rst_i, input, 1, asynchronous, active-high reset.
- wb_adr_o, output, 3, UART register index (0 RBR/THR/DLL, 1 IER/DLM, 2 FCR, 3 LCR, 5 LSR).
- wb_dat_o, output, 8, write data.
- wb_dat_i, input, 8, read data.
- wb_we_o, output, 1, write enable.
- wb_cyc_o, output, 1, bus cycle.
- wb_stb_o, output, 1, strobe.
- wb_ack_i, input, 1, slave acknowledge.
- tx_data_i, input, 8, byte to transmit.
- tx_valid_i, input, 1, TX byte offered.
- tx_ready_o, output, 1, TX byte accepted this cycle when high together with tx_valid_i.
- rx_data_o, output, 8, received byte.
- rx_valid_o, output, 1, rx_data_o holds a byte.
- rx_ready_i, input, 1, consumer takes the byte.
- reconfig_i, input, 1, single-cycle request to rerun the configuration sequence.
- cfg_done_o, output, 1, configuration complete.
- rx_overrun_o, output, 1, sticky: LSR[1] was seen set.
- bus_err_o, output, 1, sticky: an ack timeout occurred.

Behaviour:
- Reset values: all wb_* outputs 0; tx_ready_o, rx_valid_o, cfg_done_o, rx_overrun_o, bus_err_o 0; rx_data_o 8'h00; state CFG0.
- Bus transaction:
  - Outputs are registered. cyc and stb assert together and are held with stable adr, dat and we until ack.
  - Read data is captured in the ack cycle. cyc and stb drop in the next cycle.
  - There is at least one idle cycle between transactions.
  - If ack is absent for ACK_TIMEOUT cycles: drop cyc/stb, set bus_err_o, treat read data as 8'h00, and continue the sequence.
- Configuration states, one write each, in order:
  - CFG0: LCR = LCR_VAL|8'h80
  - CFG1: DLL = DIVISOR[7:0]
  - CFG2: DLM = DIVISOR[15:8]
  - CFG3: LCR = LCR_VAL&8'h7F
  - CFG4: FCR = FCR_VAL
  - CFG5: IER = 8'h00
  - Then set cfg_done_o and go to POLL.
- POLL: read LSR.
  - If LSR[1] is set, set rx_overrun_o.
  - If LSR[0]=1 and the RX holding register is empty, go to RD_RBR (RX has priority).
  - Else if LSR[5]=1 and tx_valid_i=1, go to TX_WAIT with burst count 0.
  - Else go to GAP, wait POLL_GAP cycles, then return to POLL.
- RD_RBR: read reg 0; load rx_data_o, set rx_valid_o, return to POLL.
- TX_WAIT: tx_ready_o=1 combinationally while burst count < 16.
  - On tx_valid_i&tx_ready_o: latch the byte, go to WR_THR, increment the count.
  - If tx_valid_i=0 or count=16: return to POLL. 16 is the limit because THRE guarantees an empty 16-byte FIFO.
- WR_THR: write the latched byte to reg 0, then return to TX_WAIT.
- RX holding register: cleared on rx_valid_o&rx_ready_i. No RBR read is issued while it is full, so the UART FIFO provides backpressure.
- reconfig_i:
  - Sampled in POLL, GAP or TX_WAIT (the TX_WAIT case applies only before a handshake in that cycle).
  - Clears cfg_done_o and goes to CFG0.
  - A transaction already in flight always completes first.
  - reconfig_i is ignored while cfg_done_o=0.
- tx_ready_o is 0 while cfg_done_o=0.
- rx_overrun_o and bus_err_o clear only on reset.
- Reset mid-transaction: cyc and stb drop immediately (asynchronous reset), and configuration restarts.

Test Plan:
- Reset release, DIVISOR=27 -> writes (3,0x83),(0,0x1B),(1,0x00),(3,0x03),(2,0x07),(1,0x00) in order; cfg_done_o rises after the 6th ack; no other bus activity before it.
- Loopback (UART TX wired to RX of a second uart_top), client sends 0x55,0xAA,0x0F -> same bytes arrive on rx_data_o in order; each RBR read is preceded by an LSR read with bit0=1.
- tx_valid_i held with 20 bytes, THRE=1 -> exactly 16 THR writes, then an LSR poll before the 17th byte; tx_ready_o never high during a bus transaction.
- rx_ready_i held 0, UART receives 3 bytes -> one byte presented; no further RBR reads until rx_ready_i=1; remaining 2 bytes then delivered in order.
- Slave never acks the LSR read -> cyc drops after 255 cycles, bus_err_o=1, polling continues.
- reconfig_i pulse in GAP -> cfg_done_o drops and the 6-write sequence repeats; async reset mid-write drops cyc the same cycle.
